// File: rtl/rrf_commit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rrf_commit                                                       |
// | Purpose : Committed architectural-to-physical map (RRF), updated by ROB     |
// |           commits; superseded physical registers are queued for the free   |
// |           list. Optional macro RRF_COMMIT_BYPASS_EN makes rrf_copy show     |
// |           this cycle's commits combinationally.                            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module rrf_commit #(
  parameter int PROCESSOR_WIDTH = 2,
  parameter int ARCH_REGS       = 32,
  parameter int ARCH_WIDTH      = 5,
  parameter int PHYS_WIDTH      = 6,
  parameter int FREE_FIFO_DEPTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [PROCESSOR_WIDTH-1:0]            commit_valid,
  input  logic [PROCESSOR_WIDTH*ARCH_WIDTH-1:0] commit_arch_dst,
  input  logic [PROCESSOR_WIDTH*PHYS_WIDTH-1:0] commit_phys_dst,
  output logic                                  commit_ready,
  output logic                                  free_valid,
  output logic [PHYS_WIDTH-1:0]                 free_preg,
  input  logic                                  free_ready,
  output logic [ARCH_REGS*PHYS_WIDTH-1:0]       rrf_copy
);

  localparam int PTR_W = $clog2(FREE_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(FREE_FIFO_DEPTH - PROCESSOR_WIDTH);

  logic [PHYS_WIDTH-1:0] rrf_table  [ARCH_REGS];
  logic [PHYS_WIDTH-1:0] table_next [ARCH_REGS];
  logic [PHYS_WIDTH-1:0] fifo_mem   [FREE_FIFO_DEPTH];

  logic [ARCH_WIDTH-1:0] lane_arch  [PROCESSOR_WIDTH];
  logic [PHYS_WIDTH-1:0] lane_phys  [PROCESSOR_WIDTH];
  logic [PHYS_WIDTH-1:0] lane_stale [PROCESSOR_WIDTH];
  logic [PTR_W-1:0]      push_slot  [PROCESSOR_WIDTH];
  logic [PROCESSOR_WIDTH-1:0] push_en;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] push_cnt;
  logic             pop;

  for (genvar i = 0; i < PROCESSOR_WIDTH; i++) begin : g_lane
    assign lane_arch[i] = commit_arch_dst[i*ARCH_WIDTH +: ARCH_WIDTH];
    assign lane_phys[i] = commit_phys_dst[i*PHYS_WIDTH +: PHYS_WIDTH];
  end

  // Lanes are applied oldest-first onto a working copy of the table, so each
  // lane reads the mapping left by any older same-destination lane as its
  // stale register, and the youngest lane's write is the one that survives.
  always_comb begin
    table_next = rrf_table;
    push_cnt   = '0;
    push_en    = '0;
    for (int i = 0; i < PROCESSOR_WIDTH; i++) begin
      push_slot[i]  = '0;
      lane_stale[i] = '0;
    end
    for (int i = 0; i < PROCESSOR_WIDTH; i++) begin
      if (commit_valid[i] && commit_ready && (lane_arch[i] != '0)) begin
        push_en[i]               = 1'b1;
        push_slot[i]             = tail + push_cnt[PTR_W-1:0];
        lane_stale[i]            = table_next[lane_arch[i]];
        table_next[lane_arch[i]] = lane_phys[i];
        push_cnt                 = push_cnt + 1'b1;
      end
    end
  end

  assign commit_ready = (count <= READY_MAX);
  assign free_valid   = (count != '0);
  assign free_preg    = free_valid ? fifo_mem[head] : '0;
  assign pop          = free_valid && free_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rrf_table[i] <= PHYS_WIDTH'(i);
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      rrf_table <= table_next;
      tail      <= tail + push_cnt[PTR_W-1:0];
      if (pop) begin
        head <= head + 1'b1;
      end
      count <= count + push_cnt - CNT_W'(pop);
    end
  end

  // Storage needs no reset: the occupancy count alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PROCESSOR_WIDTH; i++) begin
      if (push_en[i]) begin
        fifo_mem[push_slot[i]] <= lane_stale[i];
      end
    end
  end

  for (genvar i = 0; i < ARCH_REGS; i++) begin : g_copy
`ifdef RRF_COMMIT_BYPASS_EN
    assign rrf_copy[i*PHYS_WIDTH +: PHYS_WIDTH] = table_next[i];
`else
    assign rrf_copy[i*PHYS_WIDTH +: PHYS_WIDTH] = rrf_table[i];
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_rrf_commit.sv
`default_nettype none
// Scoreboard bench for rrf_commit: stimulus queues expected stale registers,
// a negedge monitor compares them as the free channel hands them out.
module tb_rrf_commit;

  localparam int PW = 2;
  localparam int AW = 5;
  localparam int XW = 6;
  localparam int NR = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [PW-1:0]     commit_valid = '0;
  logic [PW*AW-1:0]  commit_arch_dst = '0;
  logic [PW*XW-1:0]  commit_phys_dst = '0;
  logic              commit_ready;
  logic              free_valid;
  logic [XW-1:0]     free_preg;
  logic              free_ready = 1'b1;
  logic [NR*XW-1:0]  rrf_copy;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_q[$];
  int mdl[NR];

  rrf_commit dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_arch_dst(commit_arch_dst),
    .commit_phys_dst(commit_phys_dst), .commit_ready(commit_ready),
    .free_valid(free_valid), .free_preg(free_preg), .free_ready(free_ready),
    .rrf_copy(rrf_copy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int copy_at(input int i);
    return int'(rrf_copy[i*XW +: XW]);
  endfunction

  // Monitor: every handshake on the free channel must match the queue head.
  always @(negedge clk) begin
    if (!rst && free_valid && free_ready) begin
      if (exp_q.size() == 0) begin
        check("free_unexpected", int'(free_preg), -1);
      end else begin
        check("free_preg", int'(free_preg), exp_q.pop_front());
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mdl[i] = i;
    exp_q.delete();
  endtask

  // Called just after a posedge; the bundle is accepted at the next posedge.
  task automatic commit(input logic [1:0] v, input int a0, input int p0,
                        input int a1, input int p1);
    commit_valid    = v;
    commit_arch_dst = {AW'(a1), AW'(a0)};
    commit_phys_dst = {XW'(p1), XW'(p0)};
    if (v[0] && a0 != 0) begin exp_q.push_back(mdl[a0]); mdl[a0] = p0; end
    if (v[1] && a1 != 0) begin exp_q.push_back(mdl[a1]); mdl[a1] = p1; end
    @(posedge clk); #1;
    commit_valid = '0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 40; c++) begin
      if (exp_q.size() == 0 && !free_valid) break;
      @(posedge clk); #1;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int ok;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    ok = 1;
    for (int i = 0; i < NR; i++) if (copy_at(i) != i) ok = 0;
    check("reset_rrf_identity", ok, 1);
    check("reset_commit_ready", int'(commit_ready), 1);
    check("reset_free_valid", int'(free_valid), 0);
    check("reset_free_preg", int'(free_preg), 0);

    // Single commit
    @(posedge clk); #1;
    commit(2'b01, 5, 40, 0, 0);
    @(negedge clk);
    check("single_copy5", copy_at(5), 40);
    check("single_free_valid", int'(free_valid), 1);
    check("single_free_preg", int'(free_preg), 5);
    wait_drain();

    // Same bundle, same destination: stale order 3 then 33
    commit(2'b11, 3, 33, 3, 34);
    @(negedge clk);
    check("samedst_copy3", copy_at(3), 34);
    check("samedst_head", int'(free_preg), 3);
    wait_drain();

    // x0 commit has no effect
    commit(2'b01, 0, 50, 0, 0);
    @(negedge clk);
    check("x0_copy0", copy_at(0), 0);
    check("x0_free_valid", int'(free_valid), 0);
    @(posedge clk); #1;

    // Backpressure
    free_ready = 1'b0;
    commit(2'b11, 8, 41, 9, 42);
    commit(2'b11, 10, 43, 11, 44);
    commit(2'b11, 12, 45, 13, 46);
    @(negedge clk);
    check("bp_ready_at6", int'(commit_ready), 1);
    @(posedge clk); #1;
    commit(2'b11, 14, 47, 15, 48);
    @(negedge clk);
    check("bp_ready_at8", int'(commit_ready), 0);
    check("bp_head", int'(free_preg), 8);
    @(posedge clk); #1;
    // Bundle offered while not ready must be ignored (no model update)
    commit_valid    = 2'b11;
    commit_arch_dst = {AW'(17), AW'(16)};
    commit_phys_dst = {XW'(50), XW'(49)};
    @(posedge clk); #1;
    commit_valid = '0;
    @(negedge clk);
    check("bp_ignored16", copy_at(16), 16);
    check("bp_ignored17", copy_at(17), 17);
    check("bp_copy15", copy_at(15), 48);
    @(posedge clk); #1;
    free_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_ready_at7", int'(commit_ready), 0);
    @(negedge clk);
    check("bp_ready_at6_again", int'(commit_ready), 1);
    @(posedge clk); #1;
    wait_drain();

    // Wrap-around stream, with one lane-1-only bundle
    for (int k = 0; k < 20; k++) begin
      if (k == 10) commit(2'b10, 0, 0, 25, 61);
      else         commit(2'b01, 18 + (k % 6), 10 + k, 0, 0);
    end
    wait_drain();
    check("wrap_copy25", copy_at(25), 61);
    check("wrap_copy23", copy_at(23), 27);

    // Bypass visibility of rrf_copy
    commit_valid    = 2'b01;
    commit_arch_dst = {AW'(0), AW'(7)};
    commit_phys_dst = {XW'(0), XW'(60)};
    exp_q.push_back(mdl[7]); mdl[7] = 60;
    @(negedge clk);
`ifdef RRF_COMMIT_BYPASS_EN
    check("bypass_same_cycle", copy_at(7), 60);
`else
    check("nobypass_same_cycle", copy_at(7), 7);
`endif
    @(posedge clk); #1;
    commit_valid = '0;
    @(negedge clk);
    check("bypass_next_cycle", copy_at(7), 60);
    @(posedge clk); #1;
    wait_drain();

    // Reset mid-operation discards queued entries and restores the table
    free_ready = 1'b0;
    commit(2'b01, 4, 20, 0, 0);
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    free_ready = 1'b1;
    @(negedge clk);
    check("midrst_free_valid", int'(free_valid), 0);
    check("midrst_copy4", copy_at(4), 4);
    check("midrst_copy7", copy_at(7), 7);
    check("midrst_ready", int'(commit_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
